// File: rtl/jump_trajectory.sv
// Ballistic jump generator: on an armed launch request it integrates a fixed-point
// vertical velocity under gravity and advances x at a constant rate until landing.
module jump_trajectory #(
    parameter int TICK_DIV = 420000,
    parameter int GRAVITY  = 4,
    parameter int VX_SHIFT = 2
) (
    input  logic        clk_machine,
    input  logic        rst_machine,
    input  logic        i_jump_en,
    input  logic [7:0]  i_jump_v_init,
    input  logic [31:0] i_x_start,
    output logic [31:0] o_jump_dist,
    output logic [31:0] o_jump_height,
    output logic        o_jump_done,
    output logic        o_busy
);

    // state  | meaning
    // IDLE   | waiting; arm set whenever enable is seen low
    // LAUNCH | latch start x and velocities, clear tick counter and arm
    // FLY    | one physics step every TICK_DIV cycles until landing
    // DONE   | single-cycle landing pulse, then back to IDLE

    localparam int TICK_W = 20;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_FLY, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  arm_q, arm_d;
    logic [31:0]           dist_q, dist_d;
    logic signed [31:0]    height_q, height_d;
    logic signed [15:0]    vy_q, vy_d;
    logic [7:0]            vx_q, vx_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic signed [31:0]    h_next;
    logic                  step;

    assign step   = (tick_q == TICK_W'(TICK_DIV - 1));
    assign h_next = height_q + $signed({{16{vy_q[15]}}, vy_q});

    always_ff @(posedge clk_machine or posedge rst_machine) begin
        if (rst_machine) begin
            state_q  <= S_IDLE;
            arm_q    <= 1'b0;
            dist_q   <= '0;
            height_q <= '0;
            vy_q     <= '0;
            vx_q     <= '0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            arm_q    <= arm_d;
            dist_q   <= dist_d;
            height_q <= height_d;
            vy_q     <= vy_d;
            vx_q     <= vx_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        arm_d    = arm_q;
        dist_d   = dist_q;
        height_d = height_q;
        vy_d     = vy_q;
        vx_d     = vx_q;
        tick_d   = tick_q;
        case (state_q)
            S_IDLE: begin
                if (!i_jump_en) arm_d = 1'b1;
                if (i_jump_en && arm_q) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                dist_d   = i_x_start;
                vy_d     = {8'd0, i_jump_v_init};
                vx_d     = i_jump_v_init >> VX_SHIFT;
                height_d = '0;
                tick_d   = '0;
                arm_d    = 1'b0;
                state_d  = (i_jump_v_init == 8'd0) ? S_DONE : S_FLY;
            end
            S_FLY: begin
                if (step) begin
                    tick_d = '0;
                    dist_d = dist_q + {24'd0, vx_q};
                    // Landing clamps to the block top so the output never goes negative
                    if (h_next <= 0) begin
                        height_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        height_d = h_next;
                        vy_d     = vy_q - 16'(GRAVITY);
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign o_jump_dist   = dist_q;
    assign o_jump_height = $unsigned(height_q);
    assign o_jump_done   = (state_q == S_DONE);
    assign o_busy        = (state_q == S_LAUNCH) || (state_q == S_FLY);

endmodule

// File: tb/tb_jump_trajectory.sv
// Scoreboard bench for jump_trajectory: a reference trajectory is queued at launch
// and each physics step observed on the outputs is checked against it.
module tb_jump_trajectory;

    localparam int TICK_DIV = 4;
    localparam int GRAVITY  = 4;
    localparam int VX_SHIFT = 2;

    logic        clk_machine = 1'b0;
    logic        rst_machine = 1'b1;
    logic        i_jump_en = 1'b0;
    logic [7:0]  i_jump_v_init = '0;
    logic [31:0] i_x_start = '0;
    logic [31:0] o_jump_dist;
    logic [31:0] o_jump_height;
    logic        o_jump_done;
    logic        o_busy;

    jump_trajectory #(.TICK_DIV(TICK_DIV), .GRAVITY(GRAVITY), .VX_SHIFT(VX_SHIFT)) dut (
        .clk_machine  (clk_machine),
        .rst_machine  (rst_machine),
        .i_jump_en    (i_jump_en),
        .i_jump_v_init(i_jump_v_init),
        .i_x_start    (i_x_start),
        .o_jump_dist  (o_jump_dist),
        .o_jump_height(o_jump_height),
        .o_jump_done  (o_jump_done),
        .o_busy       (o_busy)
    );

    always #5 clk_machine = ~clk_machine;

    typedef struct {
        logic [31:0] d;
        logic [31:0] h;
        bit          last;
        bit          imm;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   exp_done = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference trajectory straight from the step equations
    task automatic push_flight(input logic [31:0] x, input logic [7:0] v);
        int          h;
        int          hn;
        int          vy;
        int          vx;
        logic [31:0] d;
        bit          landed;
        exp_done++;
        if (v == 8'd0) begin
            exp_q.push_back(exp_t'{x, 32'd0, 1'b1, 1'b1});
        end else begin
            h = 0; vy = int'(v); vx = int'(v) >> VX_SHIFT; d = x; landed = 0;
            while (!landed) begin
                hn = h + vy;
                d  = d + 32'(vx);
                if (hn <= 0) begin
                    exp_q.push_back(exp_t'{d, 32'd0, 1'b1, 1'b0});
                    landed = 1;
                end else begin
                    exp_q.push_back(exp_t'{d, 32'(hn), 1'b0, 1'b0});
                    h  = hn;
                    vy = vy - GRAVITY;
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_machine);
        #2;
    endtask

    task automatic launch(input logic [31:0] x, input logic [7:0] v);
        i_jump_en = 1'b0;
        cyc(2);
        i_x_start     = x;
        i_jump_v_init = v;
        push_flight(x, v);
        i_jump_en = 1'b1;
        cyc(1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || o_busy || o_jump_done) && k < budget) begin
            cyc(1);
            k++;
        end
        cyc(2);
        check_eq({tag, "_idle"}, {31'd0, o_busy, 32'(exp_q.size())}, 64'd0);
    endtask

    always @(negedge clk_machine) if (o_jump_done) done_cnt++;

    initial begin : monitor
        exp_t e;
        int   cyc_n;
        bit   fin;
        forever begin
            @(negedge clk_machine);
            if (rst_machine || !o_busy) continue;
            @(negedge clk_machine);
            cyc_n = 0;
            fin   = 0;
            while (!fin) begin
                if (rst_machine) begin
                    fin = 1;
                end else if (exp_q.size() == 0) begin
                    check_eq("flight_expected", 32'(exp_q.size()), 64'd1);
                    fin = 1;
                end else if ((exp_q[0].imm && cyc_n == 0) || cyc_n == TICK_DIV) begin
                    e = exp_q.pop_front();
                    check_eq("step_dist", o_jump_dist, e.d);
                    check_eq("step_height", o_jump_height, e.h);
                    check_eq("step_done", o_jump_done, e.last);
                    cyc_n = 0;
                    if (e.last) begin
                        @(negedge clk_machine);
                        check_eq("done_single", o_jump_done, 1'b0);
                        check_eq("idle_after_done", o_busy, 1'b0);
                        fin = 1;
                    end
                end
                if (!fin) begin
                    @(negedge clk_machine);
                    cyc_n++;
                end
            end
        end
    end

    initial begin : stim
        int k;
        cyc(3);
        check_eq("rst_dist", o_jump_dist, 0);
        check_eq("rst_height", o_jump_height, 0);
        check_eq("rst_done", o_jump_done, 0);
        check_eq("rst_busy", o_busy, 0);

        // Enable already high at reset release must not launch
        i_jump_en   = 1'b1;
        rst_machine = 1'b0;
        cyc(12);
        check_eq("no_launch_after_reset", o_busy, 0);

        launch(100, 8);
        wait_idle("nominal", 200);
        check_eq("nominal_hold_dist", o_jump_dist, 110);
        check_eq("nominal_hold_height", o_jump_height, 0);

        launch(500, 0);
        wait_idle("zero_vel", 50);
        check_eq("zero_vel_dist", o_jump_dist, 500);

        launch(100, 8);
        wait_idle("held_en", 200);
        cyc(20);
        check_eq("held_en_no_relaunch", o_busy, 0);
        launch(300, 12);
        wait_idle("second_flight", 300);

        launch(100, 8);
        cyc(3);
        i_jump_v_init = 8'd200;
        i_x_start     = 32'd5;
        i_jump_en     = 1'b0;
        wait_idle("mid_change", 200);

        launch(100, 8);
        k = 0;
        while (exp_q.size() > 3 && k < 100) begin
            cyc(1);
            k++;
        end
        check_eq("reset_flight_progress", 32'(exp_q.size()), 3);
        rst_machine = 1'b1;
        #1;
        check_eq("abort_dist", o_jump_dist, 0);
        check_eq("abort_height", o_jump_height, 0);
        check_eq("abort_done", o_jump_done, 0);
        check_eq("abort_busy", o_busy, 0);
        cyc(3);
        exp_q.delete();
        exp_done--;
        rst_machine = 1'b0;
        cyc(2);
        launch(100, 8);
        wait_idle("after_abort", 200);

        launch(1000, 255);
        wait_idle("max_vel", 2000);
        check_eq("max_vel_height", o_jump_height, 0);

        check_eq("done_pulses", done_cnt, exp_done);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
